// File: rtl/afifo_wr_burst_arb.sv
// Write-side burst scheduler for the 256b->16b async width-conversion FIFO.
// Optional AFIFO_WR_ARB_STAT_EN adds per-source burst counters with stat_clr.
module afifo_wr_burst_arb #(
  parameter int DATA_WIDTH  = 256,
  parameter int DEPTH_WIDTH = 8,
  parameter int BURST_LEN   = 16,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arb_en,
  input  logic                   s0_req,
  input  logic [DATA_WIDTH-1:0]  s0_data,
  output logic                   s0_rd,
  output logic                   s0_gnt,
  input  logic                   s1_req,
  input  logic [DATA_WIDTH-1:0]  s1_data,
  output logic                   s1_rd,
  output logic                   s1_gnt,
  input  logic                   fifo_wr_full,
  input  logic [DEPTH_WIDTH:0]   fifo_wr_water_level,
  output logic                   fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  fifo_wr_data,
  output logic                   busy,
  output logic                   ovf_err
`ifdef AFIFO_WR_ARB_STAT_EN
  ,
  input  logic                   stat_clr,
  output logic [15:0]            stat_burst0,
  output logic [15:0]            stat_burst1
`endif
);

  localparam int LW    = DEPTH_WIDTH + 1;
  localparam int CMAX  = (BURST_LEN > GAP_CYCLES) ? BURST_LEN : GAP_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [LW-1:0]    FULL_LVL  = {1'b1, {DEPTH_WIDTH{1'b0}}};
  localparam logic [LW-1:0]    BURST_THR = LW'(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_B    = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_G    = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             gnt_idx;
  logic             last_gnt;
  logic [LW-1:0]    free;
  logic             can_start;
  logic             start;
  logic             pick;

  // Unsigned subtraction at DEPTH_WIDTH+1 bits; a level of 2**DEPTH_WIDTH gives free=0.
  assign free      = FULL_LVL - fifo_wr_water_level;
  assign can_start = arb_en && !fifo_wr_full && (free >= BURST_THR);
  assign start     = (state == IDLE) && can_start && (s0_req || s1_req);
  assign pick      = (s0_req && s1_req) ? ~last_gnt : s1_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      gnt_idx  <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          state   <= BURST;
          gnt_idx <= pick;
          cnt     <= '0;
        end
        BURST: if (cnt == LAST_B) begin
          state    <= GAP;
          last_gnt <= gnt_idx;
          cnt      <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        GAP: if (cnt == LAST_G) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Grants and pops decode straight from state so an async reset drops them at once.
  assign s0_gnt = (state == BURST) && !gnt_idx;
  assign s1_gnt = (state == BURST) &&  gnt_idx;
  assign s0_rd  = s0_gnt;
  assign s1_rd  = s1_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      ovf_err      <= 1'b0;
    end else begin
      fifo_wr_en <= s0_rd || s1_rd;
      if (s0_rd)      fifo_wr_data <= s0_data;
      else if (s1_rd) fifo_wr_data <= s1_data;
      // The write still goes out; the FIFO drops it, we only flag it.
      if (fifo_wr_en && fifo_wr_full) ovf_err <= 1'b1;
    end
  end

  assign busy = (state != IDLE) || fifo_wr_en;

`ifdef AFIFO_WR_ARB_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_burst0 <= '0;
      stat_burst1 <= '0;
    end else if (stat_clr) begin
      stat_burst0 <= '0;
      stat_burst1 <= '0;
    end else if (start) begin
      if (!pick && stat_burst0 != 16'hFFFF) stat_burst0 <= stat_burst0 + 16'd1;
      if ( pick && stat_burst1 != 16'hFFFF) stat_burst1 <= stat_burst1 + 16'd1;
    end
  end
`endif

endmodule
